// File: rtl/csr_ctrl_pkg.sv
// rtl/csr_ctrl_pkg.sv - shared widths, state/kind/funct3 codes and CSR addresses for csr_ctrl
package csr_ctrl_pkg;

    localparam int CSR_WIDTH       = 64;
    localparam int CSR_ADDR_WIDTH  = 12;
    localparam int INSTR_MEM_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_TRAP  = 3'd3,
        ST_VEC   = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // Request kinds and trap codes share one encoding.
    localparam logic [1:0] REQ_KIND_CSR     = 2'b00;
    localparam logic [1:0] REQ_KIND_ECALL   = 2'b01;
    localparam logic [1:0] REQ_KIND_ILLEGAL = 2'b10;
    localparam logic [1:0] REQ_KIND_MRET    = 2'b11;
    localparam logic [1:0] TRAP_NONE        = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'b10;

    localparam logic [2:0] CSR_F3_PRIV   = 3'b000;
    localparam logic [2:0] CSR_F3_CSRRW  = 3'b001;
    localparam logic [2:0] CSR_F3_CSRRS  = 3'b010;
    localparam logic [2:0] CSR_F3_CSRRC  = 3'b011;
    localparam logic [2:0] CSR_F3_RSV    = 3'b100;
    localparam logic [2:0] CSR_F3_CSRRWI = 3'b101;
    localparam logic [2:0] CSR_F3_CSRRSI = 3'b110;
    localparam logic [2:0] CSR_F3_CSRRCI = 3'b111;

    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = 12'h342;

    function automatic logic csr_is_known(input logic [CSR_ADDR_WIDTH-1:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/csr_alu.sv
// rtl/csr_alu.sv - combinational new-value and write-needed computation for CSR read-modify-write ops
module csr_alu
    import csr_ctrl_pkg::*;
(
    input  logic [2:0]           funct3,
    input  logic [CSR_WIDTH-1:0] old_val,
    input  logic [CSR_WIDTH-1:0] rs1_data,
    input  logic [4:0]           zimm,
    output logic [CSR_WIDTH-1:0] new_val,
    output logic                 write_needed
);

    logic [CSR_WIDTH-1:0] operand;

    always_comb begin
        operand      = funct3[2] ? {{(CSR_WIDTH-5){1'b0}}, zimm} : rs1_data;
        new_val      = old_val;
        write_needed = 1'b0;
        // zimm doubles as the rs1 index, so zimm==0 also means rs1=x0 for register forms.
        case (funct3)
            CSR_F3_CSRRW, CSR_F3_CSRRWI: begin
                new_val      = operand;
                write_needed = 1'b1;
            end
            CSR_F3_CSRRS, CSR_F3_CSRRSI: begin
                new_val      = old_val | operand;
                write_needed = (zimm != 5'd0);
            end
            CSR_F3_CSRRC, CSR_F3_CSRRCI: begin
                new_val      = old_val & ~operand;
                write_needed = (zimm != 5'd0);
            end
            default: begin
                new_val      = old_val;
                write_needed = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_ctrl.sv
// rtl/csr_ctrl.sv - CSR/ECALL/illegal/MRET sequencer driving the csrs register-file port
// Optional: define CSR_CTRL_UNKNOWN_TRAP_EN to trap CSR ops on unimplemented addresses.
module csr_ctrl
    import csr_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_kind,
    input  logic [2:0]                 req_funct3,
    input  logic [CSR_ADDR_WIDTH-1:0]  req_csr_addr,
    input  logic [CSR_WIDTH-1:0]       req_rs1_data,
    input  logic [4:0]                 req_zimm,
    input  logic [INSTR_MEM_WIDTH-1:0] req_pc,
    output logic [CSR_ADDR_WIDTH-1:0]  csr_read_addr,
    input  logic [CSR_WIDTH-1:0]       csr_read_data,
    output logic                       csr_we,
    output logic [CSR_ADDR_WIDTH-1:0]  csr_write_addr,
    output logic [CSR_WIDTH-1:0]       csr_write_data,
    output logic [1:0]                 csr_trap,
    output logic [INSTR_MEM_WIDTH-1:0] csr_pc,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [CSR_WIDTH-1:0]       resp_rd_data,
    output logic                       resp_redirect,
    output logic [INSTR_MEM_WIDTH-1:0] resp_redirect_pc
);

    state_t                     state_q, state_d;
    logic [1:0]                 kind_q, kind_d;
    logic [2:0]                 funct3_q, funct3_d;
    logic [CSR_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [CSR_WIDTH-1:0]       rs1_q, rs1_d;
    logic [4:0]                 zimm_q, zimm_d;
    logic [INSTR_MEM_WIDTH-1:0] pc_q, pc_d;
    logic [CSR_WIDTH-1:0]       new_q, new_d;
    logic [CSR_WIDTH-1:0]       rd_q, rd_d;
    logic                       redirect_q, redirect_d;
    logic [INSTR_MEM_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic [CSR_WIDTH-1:0] alu_new;
    logic                 alu_write;
    logic                 addr_unknown;

    csr_alu u_alu (
        .funct3       (funct3_q),
        .old_val      (csr_read_data),
        .rs1_data     (rs1_q),
        .zimm         (zimm_q),
        .new_val      (alu_new),
        .write_needed (alu_write)
    );

`ifdef CSR_CTRL_UNKNOWN_TRAP_EN
    assign addr_unknown = !csr_is_known(addr_q);
`else
    assign addr_unknown = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            kind_q        <= REQ_KIND_CSR;
            funct3_q      <= 3'd0;
            addr_q        <= '0;
            rs1_q         <= '0;
            zimm_q        <= 5'd0;
            pc_q          <= '0;
            new_q         <= '0;
            rd_q          <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            rs1_q         <= rs1_d;
            zimm_q        <= zimm_d;
            pc_q          <= pc_d;
            new_q         <= new_d;
            rd_q          <= rd_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        funct3_d         = funct3_q;
        addr_d           = addr_q;
        rs1_d            = rs1_q;
        zimm_d           = zimm_q;
        pc_d             = pc_q;
        new_d            = new_q;
        rd_d             = rd_q;
        redirect_d       = redirect_q;
        redirect_pc_d    = redirect_pc_q;
        req_ready        = 1'b0;
        csr_read_addr    = '0;
        csr_we           = 1'b0;
        csr_write_addr   = '0;
        csr_write_data   = '0;
        csr_trap         = TRAP_NONE;
        csr_pc           = '0;
        resp_valid       = 1'b0;
        resp_rd_data     = '0;
        resp_redirect    = 1'b0;
        resp_redirect_pc = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    // Reserved funct3 values on a CSR op become an illegal-instruction trap.
                    if (req_kind == REQ_KIND_CSR &&
                        (req_funct3 == CSR_F3_PRIV || req_funct3 == CSR_F3_RSV))
                        kind_d = TRAP_ILLEGAL;
                    else
                        kind_d = req_kind;
                    funct3_d      = req_funct3;
                    addr_d        = req_csr_addr;
                    rs1_d         = req_rs1_data;
                    zimm_d        = req_zimm;
                    pc_d          = req_pc;
                    new_d         = '0;
                    rd_d          = '0;
                    redirect_d    = 1'b0;
                    redirect_pc_d = '0;
                    state_d       = (kind_d == REQ_KIND_CSR) ? ST_READ : ST_TRAP;
                end
            end
            ST_READ: begin
                csr_read_addr = addr_q;
                if (addr_unknown) begin
                    kind_d  = TRAP_ILLEGAL;
                    state_d = ST_TRAP;
                end else begin
                    rd_d    = csr_read_data;
                    new_d   = alu_new;
                    state_d = alu_write ? ST_WRITE : ST_RESP;
                end
            end
            ST_WRITE: begin
                csr_we         = 1'b1;
                csr_write_addr = addr_q;
                csr_write_data = new_q;
                state_d        = ST_RESP;
            end
            ST_TRAP: begin
                csr_trap = kind_q;
                csr_pc   = pc_q;
                state_d  = ST_VEC;
            end
            ST_VEC: begin
                rd_d       = '0;
                redirect_d = 1'b1;
                if (kind_q == REQ_KIND_ECALL || kind_q == REQ_KIND_ILLEGAL) begin
                    // Direct mode only: the mtvec mode bits are dropped.
                    csr_read_addr = CSR_MTVEC;
                    redirect_pc_d = {csr_read_data[INSTR_MEM_WIDTH-1:2], 2'b00};
                end else begin
                    csr_read_addr = CSR_MEPC;
                    redirect_pc_d = csr_read_data[INSTR_MEM_WIDTH-1:0];
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid       = 1'b1;
                resp_rd_data     = rd_q;
                resp_redirect    = redirect_q;
                resp_redirect_pc = redirect_pc_q;
                if (resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// tb/tb_csr_ctrl.sv - directed self-checking bench for csr_ctrl with a small csrs peer model
module tb_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr_addr;
    logic [63:0] req_rs1_data;
    logic [4:0]  req_zimm;
    logic [31:0] req_pc;
    logic [11:0] csr_read_addr;
    logic [63:0] csr_read_data;
    logic        csr_we;
    logic [11:0] csr_write_addr;
    logic [63:0] csr_write_data;
    logic [1:0]  csr_trap;
    logic [31:0] csr_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rd_data;
    logic        resp_redirect;
    logic [31:0] resp_redirect_pc;

    csr_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_kind         (req_kind),
        .req_funct3       (req_funct3),
        .req_csr_addr     (req_csr_addr),
        .req_rs1_data     (req_rs1_data),
        .req_zimm         (req_zimm),
        .req_pc           (req_pc),
        .csr_read_addr    (csr_read_addr),
        .csr_read_data    (csr_read_data),
        .csr_we           (csr_we),
        .csr_write_addr   (csr_write_addr),
        .csr_write_data   (csr_write_data),
        .csr_trap         (csr_trap),
        .csr_pc           (csr_pc),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rd_data     (resp_rd_data),
        .resp_redirect    (resp_redirect),
        .resp_redirect_pc (resp_redirect_pc)
    );

    always #5 clk = ~clk;

    // csrs peer: not cleared by rst so a dropped write stays observable.
    logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    initial begin
        m_mstatus = '0;
        m_mtvec   = '0;
        m_mepc    = '0;
        m_mcause  = '0;
    end

    always @(posedge clk) begin
        if (csr_we) begin
            case (csr_write_addr)
                12'h300: m_mstatus <= csr_write_data;
                12'h305: m_mtvec   <= csr_write_data;
                12'h341: m_mepc    <= csr_write_data;
                12'h342: m_mcause  <= csr_write_data;
                default: ;
            endcase
        end
        if (csr_trap == 2'b01) begin
            m_mepc   <= {32'd0, csr_pc};
            m_mcause <= 64'd11;
        end else if (csr_trap == 2'b10) begin
            m_mepc   <= {32'd0, csr_pc};
            m_mcause <= 64'd2;
        end
    end

    always_comb begin
        case (csr_read_addr)
            12'h300: csr_read_data = m_mstatus;
            12'h305: csr_read_data = m_mtvec;
            12'h341: csr_read_data = m_mepc;
            12'h342: csr_read_data = m_mcause;
            default: csr_read_data = '0;
        endcase
    end

    int checks = 0;
    int failures = 0;
    int clash = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int          lat, we_n, we_lat, trap_n, trap_lat;
    logic [63:0] we_data, rd;
    logic [11:0] we_addr;
    logic [1:0]  trap_v;
    logic [31:0] trap_pc, redir_pc;
    logic        redir;

    // Called at a negedge with the DUT idle; returns at the negedge after the handshake,
    // or at the first RESP negedge when resp_ready is low.
    task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic [11:0] a,
                         input logic [63:0] r, input logic [4:0] z, input logic [31:0] p);
        req_kind = k; req_funct3 = f3; req_csr_addr = a;
        req_rs1_data = r; req_zimm = z; req_pc = p; req_valid = 1'b1;
        lat = 0; we_n = 0; we_lat = 0; trap_n = 0; trap_lat = 0;
        we_data = '0; we_addr = '0; trap_v = '0; trap_pc = '0;
        @(posedge clk);
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            if (csr_we) begin
                we_n++; we_lat = lat; we_data = csr_write_data; we_addr = csr_write_addr;
            end
            if (csr_trap != 2'b00) begin
                trap_n++; trap_lat = lat; trap_v = csr_trap; trap_pc = csr_pc;
            end
            if (csr_we && csr_trap != 2'b00) clash++;
            if (resp_valid) break;
        end
        if (!resp_valid) check("resp_timeout", 64'd0, 64'd1);
        rd = resp_rd_data; redir = resp_redirect; redir_pc = resp_redirect_pc;
        if (resp_ready) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_kind = '0; req_funct3 = '0; req_csr_addr = '0;
        req_rs1_data = '0; req_zimm = '0; req_pc = '0; resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_we_trap", {61'd0, csr_we, csr_trap}, 64'd0);
        check("rst_read_addr", {52'd0, csr_read_addr}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // CSRRW mtvec
        issue(2'b00, 3'b001, 12'h305, 64'h8000_0100, 5'd1, 32'h0);
        check("rw_we_lat", we_lat, 2);
        check("rw_we_n", we_n, 1);
        check("rw_we_data", we_data, 64'h8000_0100);
        check("rw_we_addr", {52'd0, we_addr}, 64'h305);
        check("rw_lat", lat, 3);
        check("rw_rd", rd, 64'd0);
        check("rw_redir", {63'd0, redir}, 64'd0);

        // set/clear sequence on mstatus
        issue(2'b00, 3'b001, 12'h300, 64'h0F, 5'd2, 32'h0);
        issue(2'b00, 3'b010, 12'h300, 64'hF0, 5'd5, 32'h0);
        check("rs_we_data", we_data, 64'hFF);
        check("rs_rd", rd, 64'h0F);
        issue(2'b00, 3'b111, 12'h300, 64'hFFFF, 5'd3, 32'h0);
        check("rci_we_data", we_data, 64'hFC);
        check("rci_rd", rd, 64'hFF);

        // CSRRS with x0: read only
        issue(2'b00, 3'b010, 12'h300, 64'hFFFF, 5'd0, 32'h0);
        check("rs0_we_n", we_n, 0);
        check("rs0_lat", lat, 2);
        check("rs0_rd", rd, 64'hFC);

        // ECALL through mtvec 0x203
        issue(2'b00, 3'b001, 12'h305, 64'h203, 5'd1, 32'h0);
        issue(2'b01, 3'b000, 12'h000, 64'h0, 5'd0, 32'h40);
        check("ecall_trap_n", trap_n, 1);
        check("ecall_trap_lat", trap_lat, 1);
        check("ecall_trap", {62'd0, trap_v}, 64'd1);
        check("ecall_pc", {32'd0, trap_pc}, 64'h40);
        check("ecall_we_n", we_n, 0);
        check("ecall_lat", lat, 3);
        check("ecall_redir", {63'd0, redir}, 64'd1);
        check("ecall_target", {32'd0, redir_pc}, 64'h200);
        check("ecall_rd", rd, 64'd0);
        issue(2'b00, 3'b010, 12'h342, 64'h0, 5'd0, 32'h0);
        check("ecall_mcause", rd, 64'd11);
        issue(2'b00, 3'b010, 12'h341, 64'h0, 5'd0, 32'h0);
        check("ecall_mepc", rd, 64'h40);

        // MRET through mepc 0x44
        issue(2'b00, 3'b001, 12'h341, 64'h44, 5'd1, 32'h0);
        issue(2'b11, 3'b000, 12'h000, 64'h0, 5'd0, 32'h80);
        check("mret_trap_n", trap_n, 1);
        check("mret_trap", {62'd0, trap_v}, 64'd3);
        check("mret_target", {32'd0, redir_pc}, 64'h44);
        check("mret_redir", {63'd0, redir}, 64'd1);

        // funct3=100 on a CSR op becomes an illegal-instruction trap
        issue(2'b00, 3'b100, 12'h300, 64'h0, 5'd0, 32'h60);
        check("ill_trap", {62'd0, trap_v}, 64'd2);
        check("ill_we_n", we_n, 0);
        check("ill_target", {32'd0, redir_pc}, 64'h200);
        issue(2'b00, 3'b010, 12'h342, 64'h0, 5'd0, 32'h0);
        check("ill_mcause", rd, 64'd2);

        // reset while in WRITE
        req_kind = 2'b00; req_funct3 = 3'b001; req_csr_addr = 12'h300;
        req_rs1_data = 64'h1234; req_zimm = 5'd1; req_pc = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("wr_before_rst", {63'd0, csr_we}, 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", {csr_we, csr_trap, resp_valid, csr_write_data[59:0]}, 64'd0);
        check("rst_mid_ready", {63'd0, req_ready}, 64'd1);
        we_n = 0;
        repeat (2) begin
            @(negedge clk);
            if (csr_we || csr_trap != 2'b00) we_n++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (csr_we || csr_trap != 2'b00) we_n++;
        check("rst_no_activity", we_n, 0);
        issue(2'b00, 3'b010, 12'h300, 64'h0, 5'd0, 32'h0);
        check("rst_no_write", rd, 64'hFC);

        // resp_ready held low
        resp_ready = 1'b0;
        issue(2'b00, 3'b010, 12'h305, 64'h0, 5'd0, 32'h0);
        check("hold_rd0", rd, 64'h203);
        we_n = 0;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid_busy", {62'd0, resp_valid, req_ready}, 64'd2);
            if (resp_rd_data != 64'h203 || csr_we || csr_trap != 2'b00 || csr_read_addr != 12'd0)
                we_n++;
        end
        check("hold_stable", we_n, 0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_release_ready", {63'd0, req_ready}, 64'd1);
        issue(2'b00, 3'b010, 12'h300, 64'h0, 5'd0, 32'h0);
        check("b2b_lat", lat, 2);
        check("b2b_rd", rd, 64'hFC);

        check("we_trap_clash", clash, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
